// File: rtl/sram_bus_wide_pkg.sv
// Shared definitions for the wide SRAM bus slave: FSM states and parameter legality checks.
package sram_bus_wide_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PIPE = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic bit lanes_ok(input int n);
    return (n == 1) || (n == 2) || (n == 4) || (n == 8);
  endfunction

  function automatic bit latency_ok(input int n);
    return (n == 1) || (n == 2);
  endfunction

endpackage

// File: rtl/sram_bus_wide_if.sv
// Request/response bus between a fabric master and the wide SRAM slave.
interface sram_bus_wide_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_LANES  = 4
);
  localparam int AW = ADDR_WIDTH + $clog2(NUM_LANES);

  logic                      sel;
  logic                      mem_valid;
  logic [AW-1:0]             mem_addr;
  logic [NUM_LANES-1:0]      mem_wstrb;
  logic [NUM_LANES-1:0][7:0] mem_wdata;
  logic [NUM_LANES-1:0][7:0] mem_rdata;
  logic                      mem_ready;

  modport master (
    output sel, mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  sel, mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/sram_bus_ctrl.sv
// Request sequencer: accepts in IDLE, optional PIPE stage for 2-cycle reads, one-cycle RESP.
module sram_bus_ctrl
  import sram_bus_wide_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  input  logic is_write,
  output logic accept,
  output logic rd_accept,
  output logic pipe,
  output logic mem_ready
);

  state_t state, state_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) state_nxt = (is_write || READ_LATENCY == 1) ? ST_RESP : ST_PIPE;
      ST_PIPE: state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request inputs only matter in IDLE; PIPE/RESP decode purely from state.
  always_comb begin
    accept    = (state == ST_IDLE) && req;
    rd_accept = accept && !is_write;
    pipe      = (state == ST_PIPE);
    mem_ready = (state == ST_RESP);
  end

endmodule

// File: rtl/sram_bus_wide.sv
// Single-port word SRAM with byte-lane strobes behind a valid/ready bus; 1 or 2 cycle reads.
module sram_bus_wide
  import sram_bus_wide_pkg::*;
#(
  parameter int    ADDR_WIDTH    = 11,
  parameter int    NUM_LANES     = 4,
  parameter int    READ_LATENCY  = 1,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          reset_n,
  sram_bus_wide_if.slave bus
);

  localparam int LANE_BITS = $clog2(NUM_LANES);
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  if (!lanes_ok(NUM_LANES)) begin : g_bad_lanes
    $error("sram_bus_wide: NUM_LANES must be 1, 2, 4 or 8");
  end
  if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("sram_bus_wide: READ_LATENCY must be 1 or 2");
  end

  logic [NUM_LANES-1:0][7:0] mem [DEPTH];
  logic [NUM_LANES-1:0][7:0] rd_src, rdata_q;
  logic [ADDR_WIDTH-1:0]     waddr;
  logic                      accept, rd_accept, pipe, load;
  logic                      unused_addr;

  // Byte offset bits are don't-care for a word-wide access.
  assign waddr       = bus.mem_addr[ADDR_WIDTH+LANE_BITS-1:LANE_BITS];
  assign unused_addr = ^bus.mem_addr;

  sram_bus_ctrl #(.READ_LATENCY(READ_LATENCY)) u_ctrl (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (bus.sel & bus.mem_valid),
    .is_write  (|bus.mem_wstrb),
    .accept    (accept),
    .rd_accept (rd_accept),
    .pipe      (pipe),
    .mem_ready (bus.mem_ready)
  );

  // No reset on the array so it maps onto block RAM with byte enables.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (bus.mem_wstrb[i]) mem[waddr][i] <= bus.mem_wdata[i];
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign rd_src = mem[waddr];
  end else begin : g_lat2
    logic [NUM_LANES-1:0][7:0] rd_raw;
    always_ff @(posedge clk) begin
      if (rd_accept) rd_raw <= mem[waddr];
    end
    assign rd_src = rd_raw;
  end

  assign load = (READ_LATENCY == 1) ? rd_accept : pipe;

  // Output word only moves on reads, so writes leave the last read visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata_q <= '0;
    else if (load) rdata_q <= rd_src;
  end

  assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_sram_bus_wide.sv
// Scoreboard bench: READ_LATENCY=1 and =2 instances sharing clk/reset, with a byte-lane memory model.
module tb_sram_bus_wide;
  import sram_bus_wide_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sram_bus_wide_if #(.ADDR_WIDTH(11), .NUM_LANES(4)) bus0 ();
  sram_bus_wide_if #(.ADDR_WIDTH(11), .NUM_LANES(4)) bus1 ();

  sram_bus_wide #(.ADDR_WIDTH(11), .NUM_LANES(4), .READ_LATENCY(1), .MEM_INIT_FILE("")) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  sram_bus_wide #(.ADDR_WIDTH(11), .NUM_LANES(4), .READ_LATENCY(2), .MEM_INIT_FILE("")) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] model0 [int];
  logic [31:0] model1 [int];
  logic [31:0] last_rd0 = '0;
  logic [31:0] last_rd1 = '0;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the ready pulse (or in RESP when keep=1).
  task automatic txn0(input logic [12:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                      input bit drop, input bit keep, input int exp_lat, output int rcyc);
    int w;
    int lat;
    logic [31:0] e;
    w = int'(addr[12:2]);
    if (strb != 4'h0) begin
      model0[w] = merge(model0.exists(w) ? model0[w] : 32'h0, wd, strb);
      exp_q.push_back(last_rd0);
    end else begin
      last_rd0 = model0[w];
      exp_q.push_back(last_rd0);
    end
    bus0.sel = 1'b1; bus0.mem_valid = 1'b1; bus0.mem_addr = addr;
    bus0.mem_wstrb = strb; bus0.mem_wdata = wd;
    if (drop) begin
      @(posedge clk); #1;
      bus0.sel = 1'b0; bus0.mem_valid = 1'b0;
    end
    lat = 0; rcyc = -1;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      @(negedge clk);
      if (bus0.mem_ready) lat = i;
    end
    chk("lat0", 32'(lat), 32'(exp_lat));
    e = exp_q.pop_front();
    if (lat != 0) begin
      chk("rdata0", bus0.mem_rdata, e);
      rcyc = cyc;
    end
    if (!keep) begin
      bus0.sel = 1'b0; bus0.mem_valid = 1'b0; bus0.mem_wstrb = 4'h0;
      @(negedge clk);
      chk("pulse0", 32'(bus0.mem_ready), 32'h0);
    end
  endtask

  task automatic txn1(input logic [12:0] addr, input logic [3:0] strb, input logic [31:0] wd);
    int w;
    int lat;
    int exp_lat;
    logic [31:0] e;
    w = int'(addr[12:2]);
    if (strb != 4'h0) begin
      model1[w] = merge(model1.exists(w) ? model1[w] : 32'h0, wd, strb);
      exp_q.push_back(last_rd1);
      exp_lat = 1;
    end else begin
      last_rd1 = model1[w];
      exp_q.push_back(last_rd1);
      exp_lat = 2;
    end
    bus1.sel = 1'b1; bus1.mem_valid = 1'b1; bus1.mem_addr = addr;
    bus1.mem_wstrb = strb; bus1.mem_wdata = wd;
    lat = 0;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1 && exp_lat == 2)
        chk("pipe_state", 32'(u_dut1.u_ctrl.state), 32'(ST_PIPE));
      if (bus1.mem_ready) lat = i;
    end
    chk("lat1", 32'(lat), 32'(exp_lat));
    e = exp_q.pop_front();
    if (lat != 0) chk("rdata1", bus1.mem_rdata, e);
    bus1.sel = 1'b0; bus1.mem_valid = 1'b0; bus1.mem_wstrb = 4'h0;
    @(negedge clk);
    chk("pulse1", 32'(bus1.mem_ready), 32'h0);
  endtask

  initial begin
    int c1, c2, cx;
    bus0.sel = 0; bus0.mem_valid = 0; bus0.mem_addr = '0; bus0.mem_wstrb = '0; bus0.mem_wdata = '0;
    bus1.sel = 0; bus1.mem_valid = 0; bus1.mem_addr = '0; bus1.mem_wstrb = '0; bus1.mem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready0", 32'(bus0.mem_ready), 32'h0);
    chk("rst_rdata0", bus0.mem_rdata, 32'h0);
    chk("rst_ready1", 32'(bus1.mem_ready), 32'h0);
    chk("rst_rdata1", bus1.mem_rdata, 32'h0);

    // Release and present a write so the first edge after release accepts it.
    reset_n = 1'b1;
    txn0(13'h010, 4'hF, 32'hDEADBEEF, 0, 0, 1, cx);
    txn0(13'h010, 4'h0, 32'h0, 0, 0, 1, cx);

    txn0(13'h020, 4'hF, 32'h11223344, 0, 0, 1, cx);
    txn0(13'h020, 4'h5, 32'hAABBCCDD, 0, 0, 1, cx);
    txn0(13'h020, 4'h0, 32'h0, 0, 0, 1, cx);
    chk("partial_model", last_rd0, 32'h11BB33DD);

    // Master withdraws right after accept; response must still come.
    txn0(13'h044, 4'hF, 32'h0BADF00D, 1, 0, 1, cx);
    txn0(13'h044, 4'h0, 32'h0, 1, 0, 1, cx);

    txn0(13'h000, 4'hF, 32'h01010101, 0, 0, 1, cx);
    txn0(13'h004, 4'hF, 32'h02020202, 0, 0, 1, cx);
    txn0(13'h000, 4'h0, 32'h0, 0, 1, 1, c1);
    txn0(13'h004, 4'h0, 32'h0, 0, 0, 2, c2);
    chk("b2b_gap", 32'(c2 - c1), 32'd2);

    bus0.sel = 1'b0; bus0.mem_valid = 1'b1; bus0.mem_addr = 13'h010;
    bus0.mem_wstrb = 4'hF; bus0.mem_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("nosel_ready", 32'(bus0.mem_ready), 32'h0);
    end
    bus0.mem_valid = 1'b0; bus0.mem_wstrb = 4'h0;
    txn0(13'h010, 4'h0, 32'h0, 0, 0, 1, cx);

    txn1(13'h1FFC, 4'hF, 32'h5AA5C33C);
    txn1(13'h1FFC, 4'h0, 32'h0);
    txn1(13'h0008, 4'hF, 32'h12345678);
    txn1(13'h0008, 4'h3, 32'hFFFF9999);
    txn1(13'h0008, 4'h0, 32'h0);

    // Reset asserted in the RESP cycle of a write.
    txn0(13'h030, 4'hF, 32'hCAFEF00D, 0, 1, 1, cx);
    bus0.sel = 1'b0; bus0.mem_valid = 1'b0; bus0.mem_wstrb = 4'h0;
    reset_n = 1'b0;
    #1;
    chk("rst_resp_ready", 32'(bus0.mem_ready), 32'h0);
    chk("rst_resp_rdata", bus0.mem_rdata, 32'h0);
    chk("rst_rdata1b", bus1.mem_rdata, 32'h0);
    last_rd0 = '0; last_rd1 = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(bus0.mem_ready), 32'h0);
    end
    txn0(13'h030, 4'h0, 32'h0, 0, 0, 1, cx);
    txn0(13'h020, 4'h0, 32'h0, 0, 0, 1, cx);
    txn1(13'h1FFC, 4'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
